fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage of the RV32I core. It owns the program counter and drives the synchronous instruction memory: address, read enable and a one-cycle read latency.
- It delivers instructions, each tagged with its PC, through a valid/stall handshake.
- It handles branch/jump redirects with squash, single-step operation on `tick`, and a PC breakpoint with halt/resume.
- It sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- run_mode  input  1  0 = free-run, 1 = single-step.
- tick  input  1  step pulse; one fetch per tick in step mode.
- resume  input  1  pulse; leaves HALT.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  redirect target.
- bp_en  input  1  breakpoint enable.
- bp_pc  input  32  breakpoint address.
- stall  input  1  decode not accepting.
- imem_en  output  1  read enable to instruction memory.
- imem_addr  output  32  byte address to instruction memory.
- imem_rdata  input  32  instruction word; valid the cycle after imem_en.
- inst_valid  output  1  instruction presented.
- inst_pc  output  32  PC of the presented instruction.
- inst_data  output  32  presented instruction word.
- halted  output  1  sequencer in HALT.
- align_err  output  1  sticky; a misaligned redirect target was received.
- retired_count  output  32  count of delivered instructions.

Behaviour:

Reset:
- While rst=1: pc_q=RESET_PC; in-flight request and hold register cleared.
- Outputs: imem_en=0, inst_valid=0, inst_pc=0, inst_data=0, halted=0, align_err=0, retired_count=0.
- State after reset: RUN if run_mode=0, STEP if run_mode=1.
- rst asserted mid-operation overrides everything, including in-flight requests.
- First issue occurs in the first cycle with rst=0.

States: RUN, STEP, HALT.
- RUN -> STEP when run_mode=1.
- STEP -> RUN when run_mode=0.
- RUN/STEP -> HALT on breakpoint issue or on a misaligned redirect.
- HALT -> RUN/STEP on resume=1, selected by run_mode, effective the next cycle.

Issue rules (issue = imem_en=1 with imem_addr=pc_q):
- RUN: issue every cycle unless stall=1 or redirect_valid=1.
- STEP: issue only in a cycle with tick=1, stall=0 and redirect_valid=0. A tick in any other cycle is dropped.
- HALT: never issue.
- On issue, pc_q <= pc_q+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.

Response path:
- An issue in cycle N gives inst_valid=1 in N+1, with inst_pc = address issued in N and inst_data = imem_rdata.
- Delivery = inst_valid & ~stall. retired_count increments on each delivery and wraps at 2^32.
- While stall=1 and inst_valid=1, inst_valid, inst_pc and inst_data hold stable. A one-entry hold register captures imem_rdata for this.
- Because stall blocks issue, at most one instruction is outstanding or held.

Redirect (redirect_valid=1 in cycle N, any state except HALT; ignored in HALT):
- Priority: redirect > stall > tick.
- In cycle N, no issue occurs and pc_q <= redirect_pc.
- The in-flight response and the hold register are squashed, so inst_valid=0 in N+1.
- Issue of redirect_pc happens in N+1, subject to state and stall rules. inst_valid for it appears in N+2.
- If redirect_pc[1:0] != 0: squash as above, go to HALT, set align_err=1. align_err is sticky until rst.

Breakpoint:
- Triggers when an issue has imem_addr==bp_pc and bp_en=1.
- That instruction is delivered normally. The state becomes HALT from the next cycle, so halted=1 one cycle after the issue.
- pc_q already holds bp_pc+4, so a resume continues from there without retriggering.

Other rules:
- resume outside HALT is ignored.
- A resume in the same cycle as a breakpoint issue is ignored; the breakpoint wins.
- halted=1 exactly while the state is HALT.

Test Plan:
- Free-run from reset, RESET_PC=0, stall=0 -> imem_addr 0,4,8,... on consecutive cycles; inst_pc follows one cycle later; retired_count=3 three cycles after the first inst_valid.
- Stall for 3 cycles while inst_pc=8 -> inst_valid/inst_pc/inst_data stable for 3 cycles, imem_en=0; after release, next issued address is 12 with no instruction lost or duplicated.
- Redirect to 0x100 while fetching 0x10 -> in-flight instruction squashed (inst_valid=0 next cycle), imem_addr=0x100 one cycle later, inst_pc=0x100 two cycles after the redirect; redirect to 0x102 -> HALT, align_err=1.
- run_mode=1 with ticks at cycles 5 and 9, one tick during stall -> exactly two instructions delivered (pc 0, 4); the stalled tick is dropped.
- bp_en=1, bp_pc=0x20 -> instruction at 0x20 delivered, halted=1, no issue until resume; after resume, next imem_addr=0x24.
- pc_q=0xFFFF_FFFC in RUN -> next issue address 0x0; rst asserted mid-stall -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles every non-clock/reset signal of the fetch sequencer.
//   master : the fetch sequencer (drives instruction memory request and the
//            instruction output towards decode)
//   slave  : the environment (control inputs, memory read data, decode stall)
//
//   Handshake: an instruction is offered while inst_valid=1 and is taken by
//   decode in a cycle where stall=0; while stall=1 the offered
//   inst_valid/inst_pc/inst_data hold stable. imem_en=1 is a read request for
//   imem_addr whose word returns on imem_rdata in the following cycle.
//
//   dbg_state exposes the sequencer FSM state (0=RUN, 1=STEP, 2=HALT).
// ---------------------------------------------------------------------------
interface fetch_sequencer_if;
   logic        run_mode;
   logic        tick;
   logic        resume;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        bp_en;
   logic [31:0] bp_pc;
   logic        stall;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        halted;
   logic        align_err;
   logic [31:0] retired_count;
   logic [1:0]  dbg_state;

   modport master (
      input  run_mode, tick, resume, redirect_valid, redirect_pc,
             bp_en, bp_pc, stall, imem_rdata,
      output imem_en, imem_addr, inst_valid, inst_pc, inst_data,
             halted, align_err, retired_count, dbg_state
   );

   modport slave (
      output run_mode, tick, resume, redirect_valid, redirect_pc,
             bp_en, bp_pc, stall, imem_rdata,
      input  imem_en, imem_addr, inst_valid, inst_pc, inst_data,
             halted, align_err, retired_count, dbg_state
   );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Instruction-fetch control for the RV32I core. Owns the PC, issues reads
//   to a one-cycle-latency synchronous instruction memory, and presents each
//   returned word tagged with its PC to decode. Supports branch/jump redirect
//   with squash, single-step on tick, and a PC breakpoint with halt/resume.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - fetch_sequencer_if.master (control inputs, imem request/data,
//            instruction output, status, debug FSM state)
//
//   Parameter:
//     RESET_PC - word-aligned PC loaded on reset
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   fetch_sequencer_if.master  bus
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_STEP = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   // Presented instruction: valid flag, its PC, and whether its word comes
   // from the hold register (after a stall) or straight from imem_rdata.
   logic        resp_valid_q, resp_valid_d;
   logic        resp_held_q, resp_held_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   logic [31:0] hold_data_q, hold_data_d;
   logic        align_err_q, align_err_d;
   logic [31:0] retired_q, retired_d;

   logic        redirect_eff;
   logic        misaligned;
   logic        issue;
   logic        bp_hit;
   logic        deliver;
   logic [31:0] cur_data;

   // Decode of this cycle's events
   always_comb begin
      redirect_eff = bus.redirect_valid && (state_q != ST_HALT);
      misaligned   = redirect_eff && (bus.redirect_pc[1:0] != 2'b00);
      issue        = 1'b0;
      // Redirect beats stall, stall beats tick.
      if (!rst && !redirect_eff && !bus.stall) begin
         case (state_q)
            ST_RUN:  issue = 1'b1;
            ST_STEP: issue = bus.tick;
            default: issue = 1'b0;
         endcase
      end
      bp_hit   = issue && bus.bp_en && (pc_q == bus.bp_pc);
      cur_data = resp_held_q ? hold_data_q : bus.imem_rdata;
      deliver  = resp_valid_q && !bus.stall;
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      resp_valid_d = 1'b0;
      resp_held_d  = 1'b0;
      resp_pc_d    = resp_pc_q;
      hold_data_d  = hold_data_q;
      align_err_d  = align_err_q | misaligned;
      retired_d    = retired_q + {31'd0, deliver};

      case (state_q)
         ST_RUN: begin
            if (misaligned || bp_hit) state_d = ST_HALT;
            else if (bus.run_mode)    state_d = ST_STEP;
         end
         ST_STEP: begin
            if (misaligned || bp_hit) state_d = ST_HALT;
            else if (!bus.run_mode)   state_d = ST_RUN;
         end
         ST_HALT: begin
            if (bus.resume) state_d = bus.run_mode ? ST_STEP : ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      if (redirect_eff) begin
         // Squash whatever is presented or in flight.
         pc_d = bus.redirect_pc;
      end else if (issue) begin
         // Issue implies stall=0, so the currently presented word (if any)
         // is delivered this cycle and the slot frees up.
         pc_d         = pc_q + 32'd4;
         resp_valid_d = 1'b1;
         resp_pc_d    = pc_q;
      end else if (resp_valid_q && bus.stall) begin
         // Memory data is only valid for one cycle; capture it to hold.
         resp_valid_d = 1'b1;
         resp_held_d  = 1'b1;
         hold_data_d  = cur_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= bus.run_mode ? ST_STEP : ST_RUN;
         pc_q         <= RESET_PC;
         resp_valid_q <= 1'b0;
         resp_held_q  <= 1'b0;
         resp_pc_q    <= 32'd0;
         hold_data_q  <= 32'd0;
         align_err_q  <= 1'b0;
         retired_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         resp_valid_q <= resp_valid_d;
         resp_held_q  <= resp_held_d;
         resp_pc_q    <= resp_pc_d;
         hold_data_q  <= hold_data_d;
         align_err_q  <= align_err_d;
         retired_q    <= retired_d;
      end
   end

   assign bus.imem_en       = issue;
   assign bus.imem_addr     = pc_q;
   assign bus.inst_valid    = resp_valid_q;
   assign bus.inst_pc       = resp_pc_q;
   assign bus.inst_data     = resp_valid_q ? cur_data : 32'd0;
   assign bus.halted        = (state_q == ST_HALT);
   assign bus.align_err     = align_err_q;
   assign bus.retired_count = retired_q;
   assign bus.dbg_state     = state_q;

endmodule
